cnn_row_feeder: RTL and testbench

//  Frame sequencer in front of the cnn conv pipeline. On i_start it reads one IMG_HxIMG_W 8-bit frame from a sync-read frame buffer.

---
 rtl/cnn_row_feeder.sv | 190 +++++++++++++++++++
 tb/tb_cnn_row_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_row_feeder.sv
// Frame sequencer: streams one IMG_H x IMG_W frame from a sync-read buffer into the cnn row by row.
// Latency: each pixel lands on o_data 2 cycles after its read strobe (RAM 1 + output register 1).
// Backpressure: after the prefill rows, each further row is released by one i_intr rising edge (max one held credit).
//
// Ports:
//   axi_clk, axi_rst            clock, synchronous active-high reset
//   i_start / o_busy / o_done   frame start (IDLE only), busy outside IDLE, 1-cycle completion pulse
//   o_mem_rd_en/_addr, i_mem_rd_data   frame-buffer read port, data valid 1 cycle after the strobe
//   o_data_valid / o_data       pixel stream to the cnn
//   i_intr                      cnn row-request, rising-edge sensitive
//   i_res_valid                 one cnn result beat
//   o_row_idx                   logical rows issued so far
module cnn_row_feeder #(
  parameter int IMG_W        = 28,
  parameter int IMG_H        = 28,
  parameter int PREFILL_ROWS = 4,
  parameter int PIX_W        = 8,
  parameter int ADDR_W       = 10,
  parameter int RES_COUNT    = 196,
  parameter int FLIP_ROWS    = 1
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic [PIX_W-1:0]  i_mem_rd_data,
  output logic              o_data_valid,
  output logic [PIX_W-1:0]  o_data,
  input  logic              i_intr,
  input  logic              i_res_valid,
  output logic [4:0]        o_row_idx
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RES_W = $clog2(RES_COUNT + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [4:0]       ROWS     = 5'(IMG_H);
  // Prefill never asks for more rows than the frame holds.
  localparam logic [4:0]       PRE_TGT  = (PREFILL_ROWS >= IMG_H) ? 5'(IMG_H) : 5'(PREFILL_ROWS);
  localparam logic [RES_W-1:0] RES_MAX  = RES_W'(RES_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_GAP,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [4:0]       row, row_n;
  logic [COL_W-1:0] col, col_n;
  logic [4:0]       tgt, tgt_n;
  logic [RES_W-1:0] res_cnt;
  logic             intr_q;
  logic             intr_pend;
  logic             intr_rise;
  logic             consume;
  logic             rd_en;
  logic             rd_vld_q;
  logic [4:0]       row_inc;
  logic [ADDR_W-1:0] srow;

  assign intr_rise = i_intr & ~intr_q;
  assign row_inc   = row + 5'd1;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      tgt   <= '0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      tgt   <= tgt_n;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    tgt_n   = tgt;
    rd_en   = 1'b0;
    consume = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_n = S_FILL;
          row_n   = '0;
          col_n   = '0;
          tgt_n   = PRE_TGT;
        end
      end
      S_FILL: begin
        rd_en = 1'b1;
        if (col == COL_LAST) begin
          col_n = '0;
          row_n = row_inc;
          if (row_inc == tgt) state_n = S_GAP;
        end else begin
          col_n = col + COL_W'(1);
        end
      end
      S_GAP: begin
        // A credit already held when the burst ends releases the next row
        // right after this idle cycle instead of spending a cycle in WAIT.
        if (row >= ROWS) begin
          state_n = S_DRAIN;
        end else if (intr_pend) begin
          consume = 1'b1;
          tgt_n   = row_inc;
          state_n = S_FILL;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (intr_pend) begin
          consume = 1'b1;
          tgt_n   = row_inc;
          state_n = S_FILL;
        end
      end
      S_DRAIN: begin
        if (res_cnt == RES_MAX) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Row credit: a new edge outranks a same-cycle consume so it is not lost;
  // repeated edges while pending collapse into the single credit.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      intr_q    <= 1'b0;
      intr_pend <= 1'b0;
    end else begin
      intr_q <= i_intr;
      if (state == S_IDLE || state_n == S_IDLE) intr_pend <= 1'b0;
      else if (intr_rise)                      intr_pend <= 1'b1;
      else if (consume)                        intr_pend <= 1'b0;
    end
  end

  // Result beats count only inside a frame and stop at the completion value.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      res_cnt <= '0;
    end else if (state == S_IDLE) begin
      res_cnt <= '0;
    end else if (i_res_valid && res_cnt != RES_MAX) begin
      res_cnt <= res_cnt + RES_W'(1);
    end
  end

  // Valid tracks the read strobe through the RAM stage and the output register.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      rd_vld_q     <= 1'b0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
    end else begin
      rd_vld_q     <= rd_en;
      o_data_valid <= rd_vld_q;
      if (rd_vld_q) o_data <= i_mem_rd_data;
    end
  end

  assign srow = (FLIP_ROWS != 0) ? (ADDR_W'(IMG_H - 1) - ADDR_W'(row)) : ADDR_W'(row);

  assign o_mem_rd_en   = rd_en;
  assign o_mem_rd_addr = rd_en ? (srow * ADDR_W'(IMG_W) + ADDR_W'(col)) : '0;
  assign o_busy        = (state != S_IDLE);
  assign o_done        = (state == S_DONE);
  assign o_row_idx     = row;

endmodule

// File: tb/tb_cnn_row_feeder.sv
module tb_cnn_row_feeder;

  logic       axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  // Instance A: default build (bottom-up rows, 4-row prefill).
  logic       a_rst, a_start, a_intr, a_res;
  logic       a_busy, a_done, a_rd_en, a_dvalid;
  logic [9:0] a_rd_addr;
  logic [7:0] a_rd_data, a_data;
  logic [4:0] a_row_idx;

  // Instance B: top-down rows, whole frame as prefill.
  logic       b_rst, b_start, b_intr, b_res;
  logic       b_busy, b_done, b_rd_en, b_dvalid;
  logic [9:0] b_rd_addr;
  logic [7:0] b_rd_data, b_data;
  logic [4:0] b_row_idx;

  cnn_row_feeder dut_a (
    .axi_clk(axi_clk), .axi_rst(a_rst), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
    .o_mem_rd_en(a_rd_en), .o_mem_rd_addr(a_rd_addr), .i_mem_rd_data(a_rd_data),
    .o_data_valid(a_dvalid), .o_data(a_data), .i_intr(a_intr), .i_res_valid(a_res),
    .o_row_idx(a_row_idx)
  );

  cnn_row_feeder #(.FLIP_ROWS(0), .PREFILL_ROWS(28)) dut_b (
    .axi_clk(axi_clk), .axi_rst(b_rst), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
    .o_mem_rd_en(b_rd_en), .o_mem_rd_addr(b_rd_addr), .i_mem_rd_data(b_rd_data),
    .o_data_valid(b_dvalid), .o_data(b_data), .i_intr(b_intr), .i_res_valid(b_res),
    .o_row_idx(b_row_idx)
  );

  // Ramp frame buffers: mem[addr] = addr % 256, one-cycle read latency.
  always @(posedge axi_clk) if (a_rd_en) a_rd_data <= a_rd_addr[7:0];
  always @(posedge axi_clk) if (b_rd_en) b_rd_data <= b_rd_addr[7:0];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame model: pixel k of the stream is logical row k/28, column k%28.
  function automatic int exp_addr(input int idx, input bit flip);
    int r, c;
    r = idx / 28;
    c = idx % 28;
    return (flip ? (27 - r) : r) * 28 + c;
  endfunction

  int cyc = 0;
  int a_rd_idx = 0, a_px_idx = 0, a_run = 0, a_tot = 0, a_done_cnt = 0;
  int b_rd_idx = 0, b_px_idx = 0, b_run = 0, b_tot = 0, b_done_cnt = 0;
  int a_runs[$], a_starts[$], b_runs[$], b_starts[$];

  // Per-cycle comparison of both instances against the frame model.
  always @(posedge axi_clk) begin
    #1;
    cyc++;
    if (a_rst) begin
      a_rd_idx = 0; a_px_idx = 0;
      if (a_run > 0) begin a_runs.push_back(a_run); a_run = 0; end
    end else begin
      if (!a_busy) begin a_rd_idx = 0; a_px_idx = 0; end
      if (a_rd_en) begin
        check("a_addr", 32'(a_rd_addr), 32'(exp_addr(a_rd_idx, 1'b1)));
        a_rd_idx++;
      end
      if (a_dvalid) begin
        check("a_pix", 32'(a_data), 32'(exp_addr(a_px_idx, 1'b1) % 256));
        a_px_idx++; a_tot++;
        if (a_run == 0) a_starts.push_back(cyc);
        a_run++;
      end else if (a_run > 0) begin
        a_runs.push_back(a_run); a_run = 0;
      end
      if (a_done) a_done_cnt++;
    end
    if (b_rst) begin
      b_rd_idx = 0; b_px_idx = 0;
      if (b_run > 0) begin b_runs.push_back(b_run); b_run = 0; end
    end else begin
      if (!b_busy) begin b_rd_idx = 0; b_px_idx = 0; end
      if (b_rd_en) begin
        check("b_addr", 32'(b_rd_addr), 32'(exp_addr(b_rd_idx, 1'b0)));
        b_rd_idx++;
      end
      if (b_dvalid) begin
        check("b_pix", 32'(b_data), 32'(exp_addr(b_px_idx, 1'b0) % 256));
        b_px_idx++; b_tot++;
        if (b_run == 0) b_starts.push_back(cyc);
        b_run++;
      end else if (b_run > 0) begin
        b_runs.push_back(b_run); b_run = 0;
      end
      if (b_done) b_done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge axi_clk);
  endtask

  task automatic wait_a_runs(input int want, input int budget);
    for (int i = 0; i < budget && a_runs.size() < want; i++) @(negedge axi_clk);
    check("a_burst_wait", 32'(a_runs.size()), 32'(want));
  endtask

  task automatic pulse_a_intr();
    a_intr = 1'b1; tick(1); a_intr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base, tot_hold;
    a_rst = 1'b1; a_start = 1'b0; a_intr = 1'b0; a_res = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_intr = 1'b0; b_res = 1'b0;
    tick(3);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_rd_en", 32'(a_rd_en), 0);
    check("rst_addr", 32'(a_rd_addr), 0);
    check("rst_valid", 32'(a_dvalid), 0);
    check("rst_data", 32'(a_data), 0);
    check("rst_row", 32'(a_row_idx), 0);
    check("rst_b_busy", 32'(b_busy), 0);
    a_rst = 1'b0; b_rst = 1'b0;
    tick(1);

    // Prefill: first read is stored row 27 (addr 756), pixel 756%256=244 two cycles later.
    a_start = 1'b1; tick(1); a_start = 1'b0;
    check("t1_rd_en", 32'(a_rd_en), 1);
    check("t1_first_addr", 32'(a_rd_addr), 756);
    check("t1_valid_c1", 32'(a_dvalid), 0);
    tick(1);
    check("t1_valid_c2", 32'(a_dvalid), 0);
    tick(1);
    check("t1_valid_first", 32'(a_dvalid), 1);
    check("t1_first_pix", 32'(a_data), 244);
    tick(30);
    a_start = 1'b1; tick(1); a_start = 1'b0;   // ignored while busy
    wait_a_runs(1, 200);
    check("t1_prefill_len", 32'(a_runs[0]), 112);
    tick(20);
    check("t1_stall_runs", 32'(a_runs.size()), 1);
    check("t1_stall_valid", 32'(a_dvalid), 0);
    check("t1_row_idx", 32'(a_row_idx), 4);
    check("t1_busy", 32'(a_busy), 1);

    // Model cnn: one intr pulse per remaining row.
    for (int k = 0; k < 24; k++) begin
      pulse_a_intr();
      wait_a_runs(k + 2, 200);
      check("t2_row_len", 32'(a_runs[k + 1]), 28);
    end
    tick(10);
    check("t2_row_idx", 32'(a_row_idx), 28);
    check("t2_total_valid", 32'(a_tot), 784);
    check("t2_total_reads", 32'(a_rd_idx), 784);
    check("t2_bursts", 32'(a_runs.size()), 25);
    check("t2_drain_busy", 32'(a_busy), 1);
    check("t2_no_done", 32'(a_done_cnt), 0);

    // 196 result beats, then done one cycle after the count completes.
    for (int i = 0; i < 196; i++) begin a_res = 1'b1; tick(1); end
    a_res = 1'b0;
    check("t4_done_early", 32'(a_done), 0);
    check("t4_busy_pre", 32'(a_busy), 1);
    tick(1);
    check("t4_done_pulse", 32'(a_done), 1);
    a_start = 1'b1;                        // same cycle as done: ignored
    tick(1);
    check("t4_done_end", 32'(a_done), 0);
    check("t4_busy_drop", 32'(a_busy), 0);
    tick(1);                               // held start now accepted from IDLE
    a_start = 1'b0;
    check("t4_restart", 32'(a_busy), 1);
    check("t4_done_cnt", 32'(a_done_cnt), 1);

    // Two edges during prefill: one credit, row 4 follows the single GAP cycle.
    base = a_runs.size();
    tick(20);
    pulse_a_intr(); tick(1); pulse_a_intr();
    wait_a_runs(base + 2, 400);
    check("t3_prefill_len", 32'(a_runs[base]), 112);
    check("t3_row4_len", 32'(a_runs[base + 1]), 28);
    check("t3_gap", 32'(a_starts[base + 1] - a_starts[base] - a_runs[base]), 1);
    tick(40);
    check("t3_one_row_only", 32'(a_runs.size()), 32'(base + 2));
    check("t3_row_idx", 32'(a_row_idx), 5);

    // Level held high for 50 cycles is a single edge.
    a_intr = 1'b1; tick(50); a_intr = 1'b0;
    tick(10);
    check("t4_hold_runs", 32'(a_runs.size()), 32'(base + 3));
    check("t4_hold_len", 32'(a_runs[base + 2]), 28);
    check("t4_hold_row", 32'(a_row_idx), 6);

    // Rows 6..9, then reset in the middle of row 10.
    for (int k = 0; k < 4; k++) begin
      pulse_a_intr();
      wait_a_runs(base + 4 + k, 200);
    end
    check("t5_row_idx", 32'(a_row_idx), 10);
    pulse_a_intr();
    for (int i = 0; i < 100 && a_rd_idx < 290; i++) tick(1);
    check("t5_mid_row10", 32'(a_row_idx), 10);
    a_rst = 1'b1; tick(1); a_rst = 1'b0;
    check("t5_valid", 32'(a_dvalid), 0);
    check("t5_busy", 32'(a_busy), 0);
    check("t5_row_clr", 32'(a_row_idx), 0);
    check("t5_data_clr", 32'(a_data), 0);
    tot_hold = a_tot;
    tick(5);
    check("t5_no_more_valid", 32'(a_tot), 32'(tot_hold));
    a_start = 1'b1; tick(1); a_start = 1'b0;
    check("t5_restart_rd", 32'(a_rd_en), 1);
    check("t5_restart_addr", 32'(a_rd_addr), 756);
    tick(2);
    check("t5_restart_valid", 32'(a_dvalid), 1);
    check("t5_restart_pix", 32'(a_data), 244);

    // Instance B: beats in IDLE are ignored, then one 784-pixel burst, no intr.
    for (int i = 0; i < 10; i++) begin b_res = 1'b1; tick(1); end
    b_res = 1'b0;
    check("t6_idle", 32'(b_busy), 0);
    b_start = 1'b1; tick(1); b_start = 1'b0;
    check("t6_first_rd", 32'(b_rd_en), 1);
    check("t6_first_addr", 32'(b_rd_addr), 0);
    for (int i = 0; i < 900 && b_runs.size() < 1; i++) tick(1);
    check("t6_burst_seen", 32'(b_runs.size()), 1);
    if (b_runs.size() > 0) check("t6_burst_len", 32'(b_runs[0]), 784);
    check("t6_reads", 32'(b_rd_idx), 784);
    check("t6_row_idx", 32'(b_row_idx), 28);
    tick(10);
    check("t6_drain_busy", 32'(b_busy), 1);
    check("t6_no_done", 32'(b_done_cnt), 0);
    for (int i = 0; i < 195; i++) begin b_res = 1'b1; tick(1); end
    b_res = 1'b0;
    tick(4);
    check("t6_done_195", 32'(b_done_cnt), 0);
    b_res = 1'b1; tick(1); b_res = 1'b0;
    tick(3);
    check("t6_done_196", 32'(b_done_cnt), 1);
    check("t6_busy_end", 32'(b_busy), 0);
    check("t6_single_burst", 32'(b_runs.size()), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
